// File: rtl/counter_ctrl_pkg.sv
// Shared definitions for the counter sequencer: default sizing and FSM state encodings.
package counter_ctrl_pkg;

    localparam int unsigned DEF_NREQ  = 4;
    localparam int unsigned DEF_WIDTH = 4;

    typedef logic [1:0] ctrl_state_t;

    localparam ctrl_state_t ST_IDLE  = 2'd0;
    localparam ctrl_state_t ST_LOAD  = 2'd1;
    localparam ctrl_state_t ST_COUNT = 2'd2;
    localparam ctrl_state_t ST_DONE  = 2'd3;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after the pointer, wrapping.
module rr_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDXW = 2
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDXW-1:0] ptr_i,
    output logic [NREQ-1:0] win_oh_o,
    output logic [IDXW-1:0] win_idx_o,
    output logic            valid_o
);

    logic [IDXW-1:0] cand;

    always_comb begin
        win_idx_o = '0;
        valid_o   = 1'b0;
        cand      = '0;
        for (int unsigned off = 0; off < NREQ; off++) begin
            cand = IDXW'((32'(ptr_i) + off) % NREQ);
            if (!valid_o && req_i[cand]) begin
                valid_o   = 1'b1;
                win_idx_o = cand;
            end
        end
        win_oh_o = valid_o ? (NREQ'(1) << win_idx_o) : '0;
    end

endmodule

// File: rtl/shared_counter_arbiter.sv
// Sequencer that arbitrates one shared down-counter among NREQ timed-delay requesters.
module shared_counter_arbiter
    import counter_ctrl_pkg::*;
#(
    parameter int unsigned NREQ  = DEF_NREQ,
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] len,
    output logic [NREQ-1:0]       grant,
    output logic                  busy,
    output logic [WIDTH-1:0]      cnt,
    output logic [NREQ-1:0]       done
);

    localparam int unsigned IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

    ctrl_state_t     state_q, state_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [NREQ-1:0] done_q,  done_d;
    logic            busy_q,  busy_d;
    logic [WIDTH-1:0] cnt_q,  cnt_d;
    logic [IDXW-1:0] ptr_q,   ptr_d;
    logic [IDXW-1:0] owner_q, owner_d;

    logic [NREQ-1:0] arb_oh;
    logic [IDXW-1:0] arb_idx;
    logic            arb_valid;
    logic [WIDTH-1:0] len_sel;
    logic            owner_req;
    logic            release_c;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDXW (IDXW)
    ) u_rr (
        .req_i     (req),
        .ptr_i     (ptr_q),
        .win_oh_o  (arb_oh),
        .win_idx_o (arb_idx),
        .valid_o   (arb_valid)
    );

    always_comb begin
        len_sel = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (owner_q == IDXW'(i)) begin
                len_sel = len[i*WIDTH +: WIDTH];
            end
        end
    end

    assign owner_req = req[owner_q];

    // Abort and normal completion share one release path: drop ownership, advance past the owner.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        busy_d    = busy_q;
        cnt_d     = cnt_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        done_d    = '0;
        release_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (arb_valid) begin
                    grant_d = arb_oh;
                    owner_d = arb_idx;
                    busy_d  = 1'b1;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (!owner_req) begin
                    release_c = 1'b1;
                end else begin
                    cnt_d = len_sel;
                    if (len_sel == '0) begin
                        state_d = ST_DONE;
                        done_d  = grant_q;
                    end else begin
                        state_d = ST_COUNT;
                    end
                end
            end
            ST_COUNT: begin
                if (!owner_req) begin
                    release_c = 1'b1;
                end else begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - WIDTH'(1);
                    end
                    if (cnt_q <= WIDTH'(1)) begin
                        state_d = ST_DONE;
                        done_d  = grant_q;
                    end
                end
            end
            ST_DONE: begin
                release_c = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (release_c) begin
            state_d = ST_IDLE;
            grant_d = '0;
            busy_d  = 1'b0;
            ptr_d   = (owner_q == IDXW'(NREQ - 1)) ? '0 : owner_q + IDXW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            done_q  <= '0;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            ptr_q   <= '0;
            owner_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
        end
    end

    assign grant = grant_q;
    assign busy  = busy_q;
    assign cnt   = cnt_q;
    assign done  = done_q;

endmodule

// File: tb/tb_shared_counter_arbiter.sv
// Bench for shared_counter_arbiter: directed scenarios plus random traffic against a timing-level model.
module tb_shared_counter_arbiter;

    localparam int  NREQ   = 4;
    localparam int  WIDTH  = 4;
    localparam time PERIOD = 10;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [NREQ-1:0]   req = '0;
    logic [NREQ*WIDTH-1:0] len = '0;
    logic [NREQ-1:0]   grant;
    logic              busy;
    logic [WIDTH-1:0]  cnt;
    logic [NREQ-1:0]   done;

    int total = 0;
    int bad   = 0;

    shared_counter_arbiter #(
        .NREQ  (NREQ),
        .WIDTH (WIDTH)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .len   (len),
        .grant (grant),
        .busy  (busy),
        .cnt   (cnt),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_len(input int i, input int v);
        len[i*WIDTH +: WIDTH] = WIDTH'(v);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        req = '0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic wait_done(input int i, input string name);
        int n;
        n = 0;
        while (!done[i] && n < 40) begin
            tick();
            n++;
        end
        check(name, 32'(done[i]), 32'd1);
    endtask

    function automatic int rlen();
        return ($urandom_range(0, 7) == 0) ? 15 : int'($urandom_range(0, 5));
    endfunction

    // Reference model: a job granted at time g latches len at g+P and completes at g+P+len*P;
    // dropping req before completion cancels it. Expected done events go to the scoreboard.
    typedef struct {
        int  idx;
        time t;
    } exp_t;

    exp_t exp_q[$];
    int   m_own = -1;
    int   m_ptr = 0;
    time  m_load_t;
    time  m_done_t;

    always @(posedge clk) begin
        if (!rst) begin
            m_own = -1;
            m_ptr = 0;
            exp_q.delete();
        end else if (m_own < 0) begin
            for (int k = 0; k < NREQ; k++) begin
                int c;
                c = (m_ptr + k) % NREQ;
                if (m_own < 0 && req[c]) begin
                    m_own    = c;
                    m_load_t = $time + PERIOD;
                    m_done_t = m_load_t;
                end
            end
        end else begin
            if ($time == m_load_t)
                m_done_t = $time + PERIOD * time'(len[m_own*WIDTH +: WIDTH]);
            if ($time <= m_done_t && !req[m_own]) begin
                m_ptr = (m_own + 1) % NREQ;
                m_own = -1;
            end else if ($time == m_done_t) begin
                exp_q.push_back('{m_own, $time + 1});
            end else if ($time > m_done_t) begin
                m_ptr = (m_own + 1) % NREQ;
                m_own = -1;
            end
        end
    end

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (done !== '0) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_unexpected: done=%b with nothing expected at t=%0t", done, $time);
            end else begin
                e = exp_q.pop_front();
                check("sb_done_vec", 32'(done), 32'(1) << e.idx);
                check("sb_done_time", 32'($time), 32'(e.t));
                check("sb_grant_in_done", 32'(grant), 32'(done));
                check("sb_cnt_in_done", 32'(cnt), 32'd0);
                check("sb_busy_in_done", 32'(busy), 32'd1);
            end
        end else if (exp_q.size() != 0 && exp_q[0].t <= $time) begin
            e = exp_q.pop_front();
            total++;
            bad++;
            $display("FAIL sb_missed: done for req %0d expected at t=%0t never seen", e.idx, e.t);
        end
    end

    initial begin
        #500000;
        bad++;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int order[$];
        int n;
        int exp_order[5] = '{0, 1, 2, 3, 0};

        // Reset holds everything quiet even with all requests raised
        req = '1;
        #1;
        for (int r = 0; r < 3; r++) begin
            check("rst_grant", 32'(grant), 32'd0);
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_cnt", 32'(cnt), 32'd0);
            check("rst_done", 32'(done), 32'd0);
            tick();
        end

        // Basic delay of 3 ticks on requester 2
        @(negedge clk);
        rst = 1'b1;
        req = 4'b0100;
        set_len(2, 3);
        tick();
        check("t1_grant", 32'(grant), 32'b0100);
        check("t1_busy", 32'(busy), 32'd1);
        for (int v = 3; v >= 1; v--) begin
            tick();
            check("t1_cnt", 32'(cnt), 32'(v));
            check("t1_nodone", 32'(done), 32'd0);
        end
        tick();
        check("t1_cnt0", 32'(cnt), 32'd0);
        check("t1_done", 32'(done), 32'b0100);
        check("t1_grant_done", 32'(grant), 32'b0100);
        @(negedge clk);
        req = '0;
        tick();
        check("t1_release_grant", 32'(grant), 32'd0);
        check("t1_release_busy", 32'(busy), 32'd0);
        check("t1_release_done", 32'(done), 32'd0);

        // Zero length: LOAD then straight to DONE
        @(negedge clk);
        req = 4'b0010;
        set_len(1, 0);
        tick();
        check("t2_grant_a", 32'(grant), 32'b0010);
        check("t2_nodone", 32'(done), 32'd0);
        tick();
        check("t2_grant_b", 32'(grant), 32'b0010);
        check("t2_done", 32'(done), 32'b0010);
        check("t2_cnt", 32'(cnt), 32'd0);
        @(negedge clk);
        req = '0;
        tick();
        check("t2_grant_off", 32'(grant), 32'd0);
        check("t2_done_off", 32'(done), 32'd0);

        // Round-robin service order from pointer 0
        do_reset();
        len = {NREQ{4'd1}};
        req = '1;
        n = 0;
        while (order.size() < 5 && n < 60) begin
            tick();
            n++;
            for (int k = 0; k < NREQ; k++)
                if (done[k]) order.push_back(k);
        end
        check("t3_count", 32'(order.size()), 32'd5);
        for (int k = 0; k < 5; k++)
            if (k < order.size()) check("t3_order", 32'(order[k]), 32'(exp_order[k]));
        @(negedge clk);
        req = '0;

        // Abort at cnt==9 with a pending request behind it
        do_reset();
        req = 4'b1000;
        set_len(3, 15);
        n = 0;
        while (!(busy && cnt == 4'd9) && n < 30) begin
            tick();
            n++;
        end
        check("t4_reach9", 32'(cnt), 32'd9);
        @(negedge clk);
        req = 4'b0001;
        set_len(0, 1);
        tick();
        check("t4_abort_grant", 32'(grant), 32'd0);
        check("t4_abort_busy", 32'(busy), 32'd0);
        check("t4_abort_cnt", 32'(cnt), 32'd9);
        check("t4_abort_done", 32'(done), 32'd0);
        tick();
        check("t4_next_grant", 32'(grant), 32'b0001);
        check("t4_hold_cnt", 32'(cnt), 32'd9);
        wait_done(0, "t4_next_done");
        @(negedge clk);
        req = '0;

        // len change after LOAD is ignored
        do_reset();
        req = 4'b0001;
        set_len(0, 5);
        tick();
        tick();
        check("t5_latched", 32'(cnt), 32'd5);
        @(negedge clk);
        set_len(0, 2);
        n = 1;
        while (!done[0] && n < 20) begin
            tick();
            n++;
        end
        check("t5_done_seen", 32'(done[0]), 32'd1);
        check("t5_latency", 32'(n), 32'd6);
        @(negedge clk);
        req = '0;

        // Asynchronous reset mid-count also resets the pointer
        do_reset();
        req = 4'b0010;
        set_len(1, 1);
        wait_done(1, "t6_first_done");
        @(negedge clk);
        req = 4'b0100;
        set_len(2, 4);
        n = 0;
        while (!(busy && cnt == 4'd2) && n < 20) begin
            tick();
            n++;
        end
        check("t6_reach2", 32'(cnt), 32'd2);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("t6_async_grant", 32'(grant), 32'd0);
        check("t6_async_busy", 32'(busy), 32'd0);
        check("t6_async_cnt", 32'(cnt), 32'd0);
        check("t6_async_done", 32'(done), 32'd0);
        tick();
        check("t6_hold_done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        req = 4'b0110;
        set_len(1, 1);
        set_len(2, 1);
        tick();
        check("t6_ptr_reset", 32'(grant), 32'b0010);
        @(negedge clk);
        req = '0;
        repeat (3) tick();

        // Random traffic, checked by the scoreboard
        do_reset();
        repeat (3000) begin
            @(negedge clk);
            for (int i = 0; i < NREQ; i++) begin
                if (req[i]) begin
                    if (done[i]) begin
                        if ($urandom_range(0, 3) != 0) req[i] = 1'b0;
                    end else if ($urandom_range(0, 59) == 0) begin
                        req[i] = 1'b0;
                    end else if ($urandom_range(0, 9) == 0) begin
                        set_len(i, rlen());
                    end
                end else if ($urandom_range(0, 3) == 0) begin
                    set_len(i, rlen());
                    req[i] = 1'b1;
                end
            end
        end
        @(negedge clk);
        req = '0;
        repeat (25) tick();
        check("sb_drained", 32'(exp_q.size()), 32'd0);
        check("end_idle_busy", 32'(busy), 32'd0);
        check("end_idle_grant", 32'(grant), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
